// File: rtl/fnd_scan_ctrl.sv
// 4-digit multiplexed FND scan controller.
// A sequential double-dabble converter feeds the scanned display register.
module fnd_scan_ctrl #(
    parameter int DIGIT_PERIOD = 12000,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [13:0] i_value,
    input  logic        i_load,
    output logic        o_busy,
    output logic [3:0]  o_digit_sel,
    output logic [3:0]  o_fnd_data,
    output logic        o_fnd_en
);

    localparam int PW = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIGIT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    state_t         state_q, state_d;
    logic [13:0]    bin_q, bin_d;
    logic [15:0]    bcd_q, bcd_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [15:0]    disp_q, disp_d;
    logic           busy_q, busy_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic [1:0]     idx_q, idx_d;
    logic [3:0]     sel_q, sel_d;
    logic [3:0]     data_q, data_d;
    logic           en_q, en_d;
    logic [15:0]    adj;
    logic           upper_zero;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        busy_d  = busy_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_load) begin
                    bin_d   = (i_value > 14'd9999) ? 14'd9999 : i_value;
                    bcd_d   = '0;
                    cnt_d   = 4'd14;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                disp_d  = bcd_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Leading-zero test covers the current digit and everything above it
    always_comb begin
        case (idx_q)
            2'd1:    upper_zero = (disp_q[15:4] == 12'd0);
            2'd2:    upper_zero = (disp_q[15:8] == 8'd0);
            2'd3:    upper_zero = (disp_q[15:12] == 4'd0);
            default: upper_zero = 1'b0;
        endcase
    end

    always_comb begin
        pre_d = pre_q + PW'(1);
        idx_d = idx_q;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = idx_q + 2'd1;
        end
        sel_d  = (pre_q == '0) ? 4'hF : ~(4'b0001 << idx_q);
        data_d = disp_q[4*idx_q +: 4];
        en_d   = !(BLANK_LZ && (idx_q != 2'd0) && upper_zero);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
            sel_q   <= 4'hF;
            data_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            en_q    <= en_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_digit_sel = sel_q;
    assign o_fnd_data  = data_q;
    assign o_fnd_en    = en_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl: one blanking and one full-display
// instance share clock, reset and load inputs.
module tb_fnd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] val;
    logic        ld;

    logic        busy_a, en_a, busy_b, en_b;
    logic [3:0]  sel_a, dat_a, sel_b, dat_b;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    logic [3:0] seq [16];

    always #5 clk = ~clk;

    fnd_scan_ctrl #(.DIGIT_PERIOD(4), .BLANK_LZ(1'b1)) u_blank (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_value     (val),
        .i_load      (ld),
        .o_busy      (busy_a),
        .o_digit_sel (sel_a),
        .o_fnd_data  (dat_a),
        .o_fnd_en    (en_a)
    );

    fnd_scan_ctrl #(.DIGIT_PERIOD(4), .BLANK_LZ(1'b0)) u_full (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_value     (val),
        .i_load      (ld),
        .o_busy      (busy_b),
        .o_digit_sel (sel_b),
        .o_fnd_data  (dat_b),
        .o_fnd_en    (en_b)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "/sel_a"}, 16'(sel_a), 16'hF);
        chk({tag, "/dat_a"}, 16'(dat_a), 16'h0);
        chk({tag, "/en_a"}, 16'(en_a), 16'h0);
        chk({tag, "/busy_a"}, 16'(busy_a), 16'h0);
        chk({tag, "/sel_b"}, 16'(sel_b), 16'hF);
        chk({tag, "/busy_b"}, 16'(busy_b), 16'h0);
    endtask

    // One full scan frame; expectations are the BCD display and enable masks
    task automatic scan_check(input string tag, input logic [15:0] dsp,
                              input logic [3:0] ena, input logic [3:0] enb);
        logic [15:0] selt;
        int pre;
        int idx;
        selt = 16'h7BDE;
        for (int i = 0; i < 16; i++) begin
            tick;
            pre = (cyc - 1) % 4;
            idx = ((cyc - 1) / 4) % 4;
            if (pre == 0) begin
                chk({tag, "/dead_a"}, 16'(sel_a), 16'hF);
                chk({tag, "/dead_b"}, 16'(sel_b), 16'hF);
            end else begin
                chk({tag, "/sel_a"}, 16'(sel_a), 16'(selt[4*idx +: 4]));
                chk({tag, "/dat_a"}, 16'(dat_a), 16'(dsp[4*idx +: 4]));
                chk({tag, "/en_a"}, 16'(en_a), 16'(ena[idx]));
                chk({tag, "/sel_b"}, 16'(sel_b), 16'(selt[4*idx +: 4]));
                chk({tag, "/dat_b"}, 16'(dat_b), 16'(dsp[4*idx +: 4]));
                chk({tag, "/en_b"}, 16'(en_b), 16'(enb[idx]));
            end
        end
    endtask

    task automatic do_load(input string tag, input logic [13:0] v);
        int nb;
        val = v;
        ld  = 1'b1;
        tick;
        ld  = 1'b0;
        nb  = 0;
        while (busy_a && nb < 40) begin
            nb++;
            tick;
        end
        chk({tag, "/busy_cycles"}, 16'(nb), 16'd15);
        tick;
    endtask

    initial begin
        seq = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
        rst = 1'b1;
        ld  = 1'b0;
        val = '0;
        #12;
        chk_reset_outs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        for (int i = 0; i < 16; i++) begin
            tick;
            chk("t1/sel", 16'(sel_a), 16'(seq[i]));
            chk("t1/dat", 16'(dat_a), 16'h0);
            if (seq[i] != 4'hF) begin
                chk("t1/en", 16'(en_a), 16'(seq[i] == 4'hE));
            end
        end

        do_load("t2", 14'd1234);
        scan_check("t2", 16'h1234, 4'b1111, 4'b1111);

        do_load("t3a", 14'd9999);
        scan_check("t3a", 16'h9999, 4'b1111, 4'b1111);
        do_load("t3b", 14'd10000);
        scan_check("t3b", 16'h9999, 4'b1111, 4'b1111);
        do_load("t3c", 14'd16383);
        scan_check("t3c", 16'h9999, 4'b1111, 4'b1111);
        do_load("t3d", 14'd0);
        scan_check("t3d", 16'h0000, 4'b0001, 4'b1111);

        val = 14'd42;
        ld  = 1'b1;
        tick;
        chk("t4/busy_rise", 16'(busy_a), 16'h1);
        val = 14'd7;
        tick;
        ld  = 1'b0;
        for (int i = 0; i < 40 && busy_a; i++) begin
            tick;
        end
        chk("t4/idle", 16'(busy_a), 16'h0);
        tick;
        scan_check("t4", 16'h0042, 4'b0011, 4'b1111);

        do_load("t5a", 14'd5);
        scan_check("t5a", 16'h0005, 4'b0001, 4'b1111);
        do_load("t5b", 14'd1005);
        scan_check("t5b", 16'h1005, 4'b1111, 4'b1111);

        val = 14'd8765;
        ld  = 1'b1;
        tick;
        ld  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
        end
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outs("t6/async");
        @(posedge clk);
        #1;
        chk_reset_outs("t6/held");
        rst = 1'b0;
        cyc = 0;
        scan_check("t6/zero", 16'h0000, 4'b0001, 4'b1111);
        do_load("t6", 14'd8765);
        scan_check("t6", 16'h8765, 4'b1111, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
